hazard_control: RTL and testbench
=================================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: Clk (input, 1, rising-edge clock) and Reset (input, 1, synchronous active-low reset, sampled only on the rising edge of Clk).
REQ-002 The module SHALL have parameter MUL_CYCLES, default 4, giving the execute latency of a multiply; legal range 2..8.
REQ-003 RSDecode  input  5  rs field of the instruction in decode.
REQ-004 RTDecode  input  5  rt field of the instruction in decode.
REQ-005 UsesRT  input  1  the instruction in decode reads rt as a source.
REQ-006 MulStart  input  1  the instruction in decode is a multi-cycle multiply.
REQ-007 RegWriteExecute  input  1  the instruction in execute writes a register.
REQ-008 MemReadExecute  input  2  load size of the instruction in execute; 0 means not a load.
REQ-009 DestRegExecute  input  5  destination register of the instruction in execute.
REQ-010 BranchTaken  input  1  a taken branch or jump is resolved in execute this cycle.
REQ-011 PCWrite  output  1  PC update enable.
REQ-012 IFIDWrite  output  1  fetch/decode register load enable.
REQ-013 IFIDFlush  output  1  clear the fetch/decode register to a NOP.
REQ-014 IDEXBubble  output  1  zero all control fields entering the decode/execute register.
REQ-015 MulBusy  output  1  the state is MUL_BUSY.
REQ-016 StallCount  output  16  saturating count of stall cycles.

Function
REQ-017 The state machine SHALL have exactly two states, RUN and MUL_BUSY, and a 3-bit down counter Cnt.
REQ-018 LoadUse SHALL be 1 when MemReadExecute!=0, RegWriteExecute=1, DestRegExecute!=0, and either DestRegExecute==RSDecode or (UsesRT=1 and DestRegExecute==RTDecode).
REQ-019 PCWrite, IFIDWrite, IFIDFlush and IDEXBubble SHALL be combinational from the state, Cnt, Reset and the current inputs, with no added register stage.
REQ-020 Priority when Reset=1 SHALL be: BranchTaken first, then MUL_BUSY, then LoadUse, then MulStart.
REQ-021 BranchTaken=1 in any state: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=1; next state RUN; Cnt is cleared to 0; a pending multiply stall is aborted.
REQ-022 In MUL_BUSY without BranchTaken: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=1; Cnt decrements; when Cnt==1 the next state is RUN, otherwise it stays MUL_BUSY.
REQ-023 In RUN with LoadUse=1 and no BranchTaken: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=1; the state stays RUN, and a simultaneous MulStart is ignored because decode is held and reissues it.
REQ-024 In RUN with MulStart=1, no LoadUse and no BranchTaken: all outputs take their pass-through values so the multiply enters execute; the next state is MUL_BUSY and Cnt is loaded with MUL_CYCLES-1.
REQ-025 The pass-through outputs (RUN, no event) SHALL be PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
REQ-026 A multiply SHALL therefore produce exactly MUL_CYCLES-1 consecutive stall cycles, beginning on the cycle after its issue cycle.
REQ-027 StallCount SHALL increment on each rising edge where Reset=1 and PCWrite=0, and SHALL saturate at 16'hFFFF.
REQ-028 MulBusy SHALL be registered and equal to (state==MUL_BUSY).

Reset
REQ-029 While Reset=0 the outputs SHALL be PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1.
REQ-030 On a rising edge with Reset=0 the block SHALL set state=RUN, Cnt=0, MulBusy=0 and StallCount=0, regardless of the other inputs.
REQ-031 If reset is asserted during MUL_BUSY, the stall SHALL be abandoned; after reset release the block starts in RUN with the pass-through outputs.

Verification
REQ-032 Load-use case: MemReadExecute=2'b11, RegWriteExecute=1, DestRegExecute=5, RSDecode=5 -> one cycle with PCWrite=0 and IDEXBubble=1; StallCount goes from 0 to 1; with MemReadExecute=0 the next cycle, outputs return to pass-through.
REQ-033 rt sensitivity: same as REQ-032 but RTDecode=5, RSDecode=6, UsesRT=0 -> no stall; the same stimulus with UsesRT=1 -> stall.
REQ-034 Register $0: DestRegExecute=0, RSDecode=0, load in execute -> no stall.
REQ-035 Multiply with MUL_CYCLES=4: MulStart pulsed for one cycle -> the issue cycle passes through, then exactly 3 cycles with PCWrite=0 and MulBusy=1, then RUN; StallCount=3.
REQ-036 Branch abort: BranchTaken=1 on the second MUL_BUSY cycle -> that cycle has IFIDFlush=1, IDEXBubble=1, PCWrite=1; RUN on the next cycle; StallCount=1.
REQ-037 Reset during MUL_BUSY, plus saturation: Reset=0 during MUL_BUSY -> StallCount=0, MulBusy=0. With PCWrite held at 0 for 65540 cycles -> StallCount holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_control.sv
//==============================================================================
// Module      : hazard_control
// Description : Pipeline hazard unit with load-use stall, multi-cycle multiply
//               hold, branch flush and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_control #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  RSDecode,
    input  logic [4:0]  RTDecode,
    input  logic        UsesRT,
    input  logic        MulStart,
    input  logic        RegWriteExecute,
    input  logic [1:0]  MemReadExecute,
    input  logic [4:0]  DestRegExecute,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        MulBusy,
    output logic [15:0] StallCount
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    localparam logic [2:0]  c_mul_load = 3'(MUL_CYCLES - 1);
    localparam logic [15:0] c_cnt_max  = 16'hFFFF;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        mul_busy_q, mul_busy_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        load_use;

    // Register $0 is never a real dependency, so it cannot cause a stall.
    assign load_use = (MemReadExecute != 2'b00) && RegWriteExecute &&
                      (DestRegExecute != 5'd0) &&
                      ((DestRegExecute == RSDecode) ||
                       (UsesRT && (DestRegExecute == RTDecode)));

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (!Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
            state_d    = RUN;
            cnt_d      = 3'd0;
        end else if (BranchTaken) begin
            PCWrite    = 1'b1;
            IFIDWrite  = 1'b1;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
            state_d    = RUN;
            cnt_d      = 3'd0;
        end else if (state_q == MUL_BUSY) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
            cnt_d      = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
                state_d = RUN;
            end
        end else if (load_use) begin
            // Decode is held, so a coincident MulStart is simply reissued later.
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end else if (MulStart) begin
            state_d = MUL_BUSY;
            cnt_d   = c_mul_load;
        end
    end

    always_comb begin
        mul_busy_d    = (state_d == MUL_BUSY);
        stall_count_d = stall_count_q;
        if (!PCWrite && (stall_count_q != c_cnt_max)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= RUN;
            cnt_q         <= 3'd0;
            mul_busy_q    <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mul_busy_q    <= mul_busy_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign MulBusy    = mul_busy_q;
    assign StallCount = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_control.sv
//==============================================================================
// Module      : tb_hazard_control
// Description : Scoreboard bench for hazard_control (MUL_CYCLES = 4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hazard_control;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  RSDecode, RTDecode, DestRegExecute;
    logic        UsesRT, MulStart, RegWriteExecute, BranchTaken;
    logic [1:0]  MemReadExecute;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy;
    logic [15:0] StallCount;

    always #5 Clk = ~Clk;

    hazard_control #(.MUL_CYCLES(4)) dut (
        .Clk(Clk), .Reset(Reset), .RSDecode(RSDecode), .RTDecode(RTDecode),
        .UsesRT(UsesRT), .MulStart(MulStart), .RegWriteExecute(RegWriteExecute),
        .MemReadExecute(MemReadExecute), .DestRegExecute(DestRegExecute),
        .BranchTaken(BranchTaken), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble), .MulBusy(MulBusy),
        .StallCount(StallCount)
    );

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic       mul;
        logic       rwe;
        logic [1:0] mre;
        logic [4:0] dst;
        logic       br;
    } stim_t;

    // ctl = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble}
    typedef struct packed {
        logic [3:0]  ctl;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    typedef struct packed {
        stim_t      s;
        logic [3:0] ctl;
        logic       busy;
    } row_t;

    localparam logic [3:0] PASS = 4'b1100;
    localparam logic [3:0] STL  = 4'b0001;
    localparam logic [3:0] BRF  = 4'b1111;
    localparam logic [3:0] RST  = 4'b0011;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] model_cnt = 16'd0;

    function automatic stim_t st(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic ut, input logic mul, input logic rwe,
                                 input logic [1:0] mre, input logic [4:0] dst, input logic br);
        stim_t s;
        s.rst_n = r; s.rs = rs; s.rt = rt; s.ut = ut; s.mul = mul;
        s.rwe = rwe; s.mre = mre; s.dst = dst; s.br = br;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    endfunction

    function automatic stim_t mul();
        return st(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 2'd0, 5'd0, 1'b0);
    endfunction

    function automatic stim_t rst();
        return st(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 2'd3, 5'd5, 1'b1);
    endfunction

    function automatic stim_t lu5();
        return st(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 2'd3, 5'd5, 1'b0);
    endfunction

    function automatic row_t rw(input stim_t s, input logic [3:0] ctl, input logic busy);
        row_t r;
        r.s = s; r.ctl = ctl; r.busy = busy;
        return r;
    endfunction

    // Apply one cycle of stimulus and queue what the outputs must show for it.
    task automatic drive(input stim_t s, input logic [3:0] ctl, input logic busy);
        exp_t e;
        @(negedge Clk);
        Reset = s.rst_n; RSDecode = s.rs; RTDecode = s.rt; UsesRT = s.ut;
        MulStart = s.mul; RegWriteExecute = s.rwe; MemReadExecute = s.mre;
        DestRegExecute = s.dst; BranchTaken = s.br;
        e.ctl = ctl; e.busy = busy; e.cnt = model_cnt;
        sb.push_back(e);
        if (!s.rst_n)
            model_cnt = 16'd0;
        else if (!ctl[3] && model_cnt != 16'hFFFF)
            model_cnt = model_cnt + 16'd1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(rw(rst(),  RST,  1'b0));
        rows.push_back(rw(rst(),  RST,  1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        foreach (rows[i]) begin
            drive(rows[i].s, rows[i].ctl, rows[i].busy);
            #4;
            e = sb.pop_front();
            o = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy, StallCount};
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset row %0d: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                         i, o.ctl, o.busy, o.cnt, e.ctl, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(rw(lu5(),  STL,  1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        rows.push_back(rw(st(1'b1, 5'd6, 5'd5, 1'b0, 1'b0, 1'b1, 2'd3, 5'd5, 1'b0), PASS, 1'b0));
        rows.push_back(rw(st(1'b1, 5'd6, 5'd5, 1'b1, 1'b0, 1'b1, 2'd3, 5'd5, 1'b0), STL,  1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        rows.push_back(rw(st(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd0, 1'b0), PASS, 1'b0));
        rows.push_back(rw(st(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd5, 1'b0), PASS, 1'b0));
        rows.push_back(rw(st(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 5'd5, 1'b0), PASS, 1'b0));
        rows.push_back(rw(st(1'b1, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 5'd9, 1'b0), STL,  1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        foreach (rows[i]) begin
            drive(rows[i].s, rows[i].ctl, rows[i].busy);
            #4;
            e = sb.pop_front();
            o = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy, StallCount};
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL load_use row %0d: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                         i, o.ctl, o.busy, o.cnt, e.ctl, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_multiply();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(rw(rst(),  RST,  1'b0));
        rows.push_back(rw(mul(),  PASS, 1'b0));
        rows.push_back(rw(idle(), STL,  1'b1));
        rows.push_back(rw(idle(), STL,  1'b1));
        rows.push_back(rw(idle(), STL,  1'b1));
        rows.push_back(rw(idle(), PASS, 1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        // Multiply under a load-use stall must not start
        rows.push_back(rw(st(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 2'd3, 5'd5, 1'b0), STL, 1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        foreach (rows[i]) begin
            drive(rows[i].s, rows[i].ctl, rows[i].busy);
            #4;
            e = sb.pop_front();
            o = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy, StallCount};
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL multiply row %0d: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                         i, o.ctl, o.busy, o.cnt, e.ctl, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_branch_abort();
        row_t  rows[$];
        exp_t  e, o;
        stim_t brs;
        brs = idle();
        brs.br = 1'b1;
        rows.push_back(rw(rst(),  RST,  1'b0));
        rows.push_back(rw(mul(),  PASS, 1'b0));
        rows.push_back(rw(idle(), STL,  1'b1));
        rows.push_back(rw(brs,    BRF,  1'b1));
        rows.push_back(rw(idle(), PASS, 1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        // Branch outranks load-use and multiply issue in RUN
        rows.push_back(rw(st(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 2'd3, 5'd5, 1'b1), BRF, 1'b0));
        rows.push_back(rw(st(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 1'b1), BRF, 1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        foreach (rows[i]) begin
            drive(rows[i].s, rows[i].ctl, rows[i].busy);
            #4;
            e = sb.pop_front();
            o = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy, StallCount};
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL branch_abort row %0d: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                         i, o.ctl, o.busy, o.cnt, e.ctl, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(rw(mul(),  PASS, 1'b0));
        rows.push_back(rw(mul(),  STL,  1'b1));
        rows.push_back(rw(mul(),  STL,  1'b1));
        rows.push_back(rw(mul(),  STL,  1'b1));
        rows.push_back(rw(mul(),  PASS, 1'b0));
        rows.push_back(rw(idle(), STL,  1'b1));
        rows.push_back(rw(idle(), STL,  1'b1));
        rows.push_back(rw(idle(), STL,  1'b1));
        rows.push_back(rw(idle(), PASS, 1'b0));
        foreach (rows[i]) begin
            drive(rows[i].s, rows[i].ctl, rows[i].busy);
            #4;
            e = sb.pop_front();
            o = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy, StallCount};
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL back_to_back row %0d: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                         i, o.ctl, o.busy, o.cnt, e.ctl, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_reset_in_busy();
        row_t rows[$];
        exp_t e, o;
        rows.push_back(rw(mul(),  PASS, 1'b0));
        rows.push_back(rw(idle(), STL,  1'b1));
        rows.push_back(rw(rst(),  RST,  1'b1));
        rows.push_back(rw(idle(), PASS, 1'b0));
        rows.push_back(rw(idle(), PASS, 1'b0));
        foreach (rows[i]) begin
            drive(rows[i].s, rows[i].ctl, rows[i].busy);
            #4;
            e = sb.pop_front();
            o = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy, StallCount};
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_in_busy row %0d: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                         i, o.ctl, o.busy, o.cnt, e.ctl, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e, o;
        for (int i = 0; i < 65542; i++) begin
            if (i < 65540)
                drive(lu5(), STL, 1'b0);
            else
                drive(idle(), PASS, 1'b0);
            #4;
            e = sb.pop_front();
            o = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulBusy, StallCount};
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL saturation cycle %0d: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                         i, o.ctl, o.busy, o.cnt, e.ctl, e.busy, e.cnt);
            end
        end
        n_cmp++;
        if (StallCount !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL saturation_final: got cnt=%h, want cnt=ffff", StallCount);
        end
    endtask

    initial begin
        Reset = 1'b0; RSDecode = '0; RTDecode = '0; UsesRT = 1'b0; MulStart = 1'b0;
        RegWriteExecute = 1'b0; MemReadExecute = '0; DestRegExecute = '0; BranchTaken = 1'b0;
        test_reset();
        test_load_use();
        test_multiply();
        test_branch_abort();
        test_back_to_back();
        test_reset_in_busy();
        drive(rst(), RST, 1'b0);
        #4;
        void'(sb.pop_front());
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
